// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an I/O page with cycle counter, console FIFO and TOHOST.
// Optional store-alignment checking with a sticky misalign output is enabled by MISALIGN_CHECK_EN.
module dmem_responder #(
   parameter int          DEPTH_LOG2      = 6,
   parameter int          FIFO_DEPTH_LOG2 = 3,
   parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        done,
   output logic [31:0] exit_code
`ifdef MISALIGN_CHECK_EN
   ,
   output logic        misalign
`endif
);

   localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

   logic [31:0]                mem [2**DEPTH_LOG2];
   logic [7:0]                 fifo_mem [2**FIFO_DEPTH_LOG2];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]   count;
   logic                       overflow;
   logic [31:0]                cycle_cnt;

   logic io_sel, store_ok, ram_we, push, push_acc, pop, full, empty;

   assign io_sel = (addr[31:8] == IO_BASE[31:8]);

`ifdef MISALIGN_CHECK_EN
   assign store_ok = memwrite & ~reset & (addr[1:0] == 2'b00);
`else
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^addr[1:0];
   assign store_ok = memwrite & ~reset;
`endif

   assign ram_we   = store_ok & ~io_sel;
   assign full     = (count == FIFO_FULL);
   assign empty    = (count == '0);
   assign push     = store_ok & io_sel & (addr[7:2] == 6'h01);
   assign pop      = tx_valid & tx_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push_acc = push & (~full | pop);
   assign tx_valid = ~empty;
   assign tx_data  = fifo_mem[rd_ptr];

   always_comb begin
      readdata = mem[addr[DEPTH_LOG2+1:2]];
      if (io_sel) begin
         case (addr[7:2])
            6'h00:   readdata = cycle_cnt;
            6'h01:   readdata = {overflow, 15'b0, {(7-FIFO_DEPTH_LOG2){1'b0}}, count,
                                 6'b0, empty, full};
            6'h02:   readdata = exit_code;
            default: readdata = 32'h0;
         endcase
      end
   end

   // Storage arrays carry data only and are never cleared.
   always_ff @(posedge clk) begin
      if (ram_we)
         mem[addr[DEPTH_LOG2+1:2]] <= writedata;
      if (push_acc)
         fifo_mem[wr_ptr] <= writedata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= 32'h0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         done      <= 1'b0;
         exit_code <= 32'h0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (push_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_acc, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push & ~push_acc)
            overflow <= 1'b1;
         if (store_ok & io_sel & (addr[7:2] == 6'h02)) begin
            done      <= 1'b1;
            exit_code <= writedata;
         end
      end
   end

`ifdef MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)
         misalign <= 1'b0;
      else if (memwrite & (addr[1:0] != 2'b00))
         misalign <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: counter, RAM aliasing, console FIFO, TOHOST, reset.
// Build with MISALIGN_CHECK_EN defined to also exercise the misalign path.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memwrite = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] writedata = 32'h0;
   logic [31:0] readdata;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        done;
   logic [31:0] exit_code;
`ifdef MISALIGN_CHECK_EN
   logic        misalign;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .addr      (addr),
      .writedata (writedata),
      .readdata  (readdata),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .done      (done),
      .exit_code (exit_code)
`ifdef MISALIGN_CHECK_EN
      ,
      .misalign  (misalign)
`endif
   );

   // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      addr = 32'hFFFF_FF00;
      #1;
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_cycle: got %h expected %h", readdata, 32'h0);
      end
      n_checks++;
      if (tx_valid !== 1'b0 || done !== 1'b0 || exit_code !== 32'h0) begin
         n_fail++; $display("FAIL reset_outputs: got valid=%b done=%b exit=%h expected 0 0 0",
                            tx_valid, done, exit_code);
      end
      reset = 1'b0;
      repeat (10) step();
      #1;
      n_checks++;
      if (readdata !== 32'd10) begin
         n_fail++; $display("FAIL cycle_count: got %0d expected %0d", readdata, 10);
      end
   endtask

   task automatic test_ram();
      addr = 32'h0000_0010; writedata = 32'hDEAD_BEEF; memwrite = 1'b1;
      step();
      addr = 32'h0000_0014; writedata = 32'h0BAD_F00D;
      step();
      memwrite = 1'b0; addr = 32'h0000_0010;
      #1;
      n_checks++;
      if (readdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL ram_read: got %h expected %h", readdata, 32'hDEAD_BEEF);
      end
      addr = 32'h0000_0110;
      #1;
      n_checks++;
      if (readdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL ram_alias: got %h expected %h", readdata, 32'hDEAD_BEEF);
      end
      addr = 32'h0000_0017;
      #1;
      n_checks++;
      if (readdata !== 32'h0BAD_F00D) begin
         n_fail++; $display("FAIL ram_lsb_ignored: got %h expected %h", readdata, 32'h0BAD_F00D);
      end
      addr = 32'hFFFF_FF0C;
      #1;
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL io_unmapped: got %h expected %h", readdata, 32'h0);
      end
   endtask

   task automatic test_fifo_overflow();
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         addr = 32'hFFFF_FF04; writedata = 32'h41 + i; memwrite = 1'b1;
         step();
      end
      memwrite = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'h8000_0801) begin
         n_fail++; $display("FAIL status_overflow: got %h expected %h", readdata, 32'h8000_0801);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
            n_fail++; $display("FAIL drain_%0d: got valid=%b data=%h expected 1 %h",
                               i, tx_valid, tx_data, 8'(8'h41 + i));
         end
         step();
      end
      #1;
      n_checks++;
      if (tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL drain_empty: got valid=%b expected 0", tx_valid);
      end
      n_checks++;
      if (readdata !== 32'h8000_0002) begin
         n_fail++; $display("FAIL status_empty: got %h expected %h", readdata, 32'h8000_0002);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_bytes [8];
      exp_bytes = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
      reset = 1'b1;
      step();
      reset = 1'b0;
      addr = 32'hFFFF_FF04;
      #1;
      n_checks++;
      if (readdata !== 32'h0000_0002) begin
         n_fail++; $display("FAIL status_after_reset: got %h expected %h", readdata, 32'h0000_0002);
      end
      for (int i = 0; i < 8; i++) begin
         writedata = 32'h61 + i; memwrite = 1'b1;
         step();
      end
      memwrite = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'h0000_0801 || tx_data !== 8'h61) begin
         n_fail++; $display("FAIL fifo_full: got status=%h head=%h expected %h %h",
                            readdata, tx_data, 32'h0000_0801, 8'h61);
      end
      tx_ready = 1'b1; writedata = 32'h5A; memwrite = 1'b1;
      step();
      memwrite = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'h0000_0801) begin
         n_fail++; $display("FAIL push_pop_full: got %h expected %h", readdata, 32'h0000_0801);
      end
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++;
         if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin
            n_fail++; $display("FAIL b2b_drain_%0d: got valid=%b data=%h expected 1 %h",
                               i, tx_valid, tx_data, exp_bytes[i]);
         end
         step();
      end
      #1;
      n_checks++;
      if (tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_empty: got valid=%b expected 0", tx_valid);
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_tohost();
      addr = 32'hFFFF_FF08; writedata = 32'h0000_002A; memwrite = 1'b1;
      step();
      memwrite = 1'b0;
      #1;
      n_checks++;
      if (done !== 1'b1 || exit_code !== 32'h2A || readdata !== 32'h2A) begin
         n_fail++; $display("FAIL tohost: got done=%b exit=%h rd=%h expected 1 2a 2a",
                            done, exit_code, readdata);
      end
      writedata = 32'h0000_0055; memwrite = 1'b1;
      step();
      // Prime RAM and the FIFO so the reset below has something to clear or protect.
      addr = 32'h0000_0040; writedata = 32'h1111_1111;
      step();
      addr = 32'hFFFF_FF04; writedata = 32'h51;
      step();
      memwrite = 1'b0;
      #1;
      n_checks++;
      if (done !== 1'b1 || exit_code !== 32'h55 || tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL tohost_overwrite: got done=%b exit=%h valid=%b expected 1 55 1",
                            done, exit_code, tx_valid);
      end
      reset = 1'b1; addr = 32'h0000_0040; writedata = 32'hCAFE_F00D; memwrite = 1'b1;
      step();
      memwrite = 1'b0; reset = 1'b0;
      #1;
      n_checks++;
      if (done !== 1'b0 || exit_code !== 32'h0 || tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_clears: got done=%b exit=%h valid=%b expected 0 0 0",
                            done, exit_code, tx_valid);
      end
      n_checks++;
      if (readdata !== 32'h1111_1111) begin
         n_fail++; $display("FAIL store_in_reset: got %h expected %h", readdata, 32'h1111_1111);
      end
   endtask

`ifdef MISALIGN_CHECK_EN
   task automatic test_misalign();
      n_checks++;
      if (misalign !== 1'b0) begin
         n_fail++; $display("FAIL misalign_init: got %b expected 0", misalign);
      end
      addr = 32'h0000_0020; writedata = 32'h5555_5555; memwrite = 1'b1;
      step();
      addr = 32'h0000_0022; writedata = 32'h0000_1234;
      step();
      memwrite = 1'b0; addr = 32'h0000_0020;
      #1;
      n_checks++;
      if (misalign !== 1'b1 || readdata !== 32'h5555_5555) begin
         n_fail++; $display("FAIL misalign: got flag=%b word=%h expected 1 %h",
                            misalign, readdata, 32'h5555_5555);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ram();
      test_fifo_overflow();
      test_back_to_back();
      test_tohost();
`ifdef MISALIGN_CHECK_EN
      test_misalign();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
